// File: rtl/biriscv_trace_buffer.sv
// Retired-instruction trace capture: arm/trigger/post-count window feeding a FWFT FIFO
// with a free-running timestamp and a ready/valid drain port.
module biriscv_trace_buffer #(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  parameter int CNT_W  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_CH-1:0]          valid_i,
  input  logic [NUM_CH*32-1:0]       pc_i,
  input  logic [NUM_CH*32-1:0]       opcode_i,
  input  logic                       arm_i,
  input  logic                       stop_i,
  input  logic                       trig_en_i,
  input  logic [31:0]                trig_pc_i,
  input  logic [CNT_W-1:0]           post_count_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_pc_o,
  output logic [31:0]                out_opcode_o,
  output logic [TS_W-1:0]            out_ts_o,
  output logic                       out_lost_o,
  output logic [1:0]                 state_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic [CNT_W-1:0]           drop_cnt_o
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LN_W  = $clog2(NUM_CH + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [TS_W-1:0]   ts_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  drop_q;
  logic [CNT_W:0]    drop_sum;
  logic              pend_lost_q;
  logic [LVL_W-1:0]  level_q, free_slots;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;

  logic [31:0]       mem_pc   [DEPTH];
  logic [31:0]       mem_op   [DEPTH];
  logic [TS_W-1:0]   mem_ts   [DEPTH];
  logic              mem_lost [DEPTH];

  logic [NUM_CH-1:0] cand, elig, wr_en, wr_lost;
  logic [PTR_W-1:0]  wr_slot [NUM_CH];
  logic [LN_W-1:0]   n_elig, n_wr, n_drop;
  logic              trig_seen;
  logic              pop;

  // Window control: stop beats arm beats capture; the post-count limit trims lanes in order.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    cand      = '0;
    elig      = '0;
    n_elig    = '0;
    trig_seen = 1'b0;
    if (stop_i) begin
      state_d = ST_DONE;
    end else if (arm_i) begin
      state_d = ST_ARMED;
      count_d = '0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (!trig_en_i) begin
            cand    = valid_i;
            state_d = ST_CAPTURE;
          end else begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
              if (valid_i[ch] && (trig_seen || pc_i[32*ch +: 32] == trig_pc_i)) begin
                cand[ch]  = 1'b1;
                trig_seen = 1'b1;
              end
            end
            if (trig_seen) state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: cand = valid_i;
        default: ;
      endcase
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        if (cand[ch] && (post_count_i == '0 ||
            ({1'b0, count_q} + (CNT_W+1)'(n_elig)) < {1'b0, post_count_i})) begin
          elig[ch] = 1'b1;
          n_elig   = n_elig + LN_W'(1);
        end
      end
      count_d = count_q + CNT_W'(n_elig);
      if (state_d == ST_CAPTURE && post_count_i != '0 && count_d >= post_count_i)
        state_d = ST_DONE;
    end
  end

  // Free space is taken from the registered level; a same-cycle pop does not free a slot.
  always_comb begin
    free_slots = LVL_W'(DEPTH) - level_q;
    wr_en      = '0;
    wr_lost    = '0;
    n_wr       = '0;
    n_drop     = '0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      wr_slot[ch] = wr_ptr_q + PTR_W'(n_wr);
      if (elig[ch]) begin
        if (LVL_W'(n_wr) < free_slots) begin
          wr_en[ch]   = 1'b1;
          wr_lost[ch] = pend_lost_q && (n_wr == '0);
          n_wr        = n_wr + LN_W'(1);
        end else begin
          n_drop = n_drop + LN_W'(1);
        end
      end
    end
    drop_sum = {1'b0, drop_q} + (CNT_W+1)'(n_drop);
  end

  assign pop = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      ts_q        <= '0;
      count_q     <= '0;
      drop_q      <= '0;
      pend_lost_q <= 1'b0;
      level_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      ts_q     <= ts_q + TS_W'(1);
      count_q  <= count_d;
      drop_q   <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      level_q  <= level_q + LVL_W'(n_wr) - LVL_W'(pop);
      wr_ptr_q <= wr_ptr_q + PTR_W'(n_wr);
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
      if (n_drop != '0)    pend_lost_q <= 1'b1;
      else if (n_wr != '0) pend_lost_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      if (rst_ni && wr_en[ch]) begin
        mem_pc[wr_slot[ch]]   <= pc_i[32*ch +: 32];
        mem_op[wr_slot[ch]]   <= opcode_i[32*ch +: 32];
        mem_ts[wr_slot[ch]]   <= ts_q;
        mem_lost[wr_slot[ch]] <= wr_lost[ch];
      end
    end
  end

  assign out_valid_o  = (level_q != '0);
  assign out_pc_o     = out_valid_o ? mem_pc[rd_ptr_q] : '0;
  assign out_opcode_o = out_valid_o ? mem_op[rd_ptr_q] : '0;
  assign out_ts_o     = out_valid_o ? mem_ts[rd_ptr_q] : '0;
  assign out_lost_o   = out_valid_o && mem_lost[rd_ptr_q];
  assign state_o      = state_q;
  assign level_o      = level_q;
  assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_biriscv_trace_buffer.sv
// Directed bench for biriscv_trace_buffer: window control, FIFO order, drops/lost flag,
// stop priority and timestamp wrap, all against hand-computed values.
module tb_biriscv_trace_buffer;
  localparam int NUM_CH = 2;
  localparam int DEPTH  = 16;
  localparam int TS_W   = 16;
  localparam int CNT_W  = 16;
  localparam logic [31:0] OPX = 32'hA5A5_0000;

  logic                       clk_i = 1'b0;
  logic                       rst_ni = 1'b0;
  logic [NUM_CH-1:0]          valid_i = '0;
  logic [NUM_CH*32-1:0]       pc_i = '0;
  logic [NUM_CH*32-1:0]       opcode_i = '0;
  logic                       arm_i = 1'b0;
  logic                       stop_i = 1'b0;
  logic                       trig_en_i = 1'b0;
  logic [31:0]                trig_pc_i = '0;
  logic [CNT_W-1:0]           post_count_i = '0;
  logic                       out_valid_o;
  logic                       out_ready_i = 1'b0;
  logic [31:0]                out_pc_o;
  logic [31:0]                out_opcode_o;
  logic [TS_W-1:0]            out_ts_o;
  logic                       out_lost_o;
  logic [1:0]                 state_o;
  logic [$clog2(DEPTH+1)-1:0] level_o;
  logic [CNT_W-1:0]           drop_cnt_o;

  biriscv_trace_buffer #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .pc_i(pc_i), .opcode_i(opcode_i),
    .arm_i(arm_i), .stop_i(stop_i), .trig_en_i(trig_en_i), .trig_pc_i(trig_pc_i),
    .post_count_i(post_count_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_pc_o(out_pc_o), .out_opcode_o(out_opcode_o), .out_ts_o(out_ts_o),
    .out_lost_o(out_lost_o), .state_o(state_o), .level_o(level_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_lanes(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1);
    valid_i  = v;
    pc_i     = {p1, p0};
    opcode_i = {p1 ^ OPX, p0 ^ OPX};
  endtask

  // After this returns the current cycle carries timestamp 0.
  task automatic do_reset();
    rst_ni = 1'b0;
    arm_i  = 1'b0;
    stop_i = 1'b0;
    set_lanes(2'b00, 32'h0, 32'h0);
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    do_reset();
    check("rst_state", state_o, 0);
    check("rst_level", level_o, 0);
    check("rst_valid", out_valid_o, 0);
    check("rst_drop",  drop_cnt_o, 0);
    check("rst_pc",    out_pc_o, 0);

    // Reset in the middle of a capture with 5 entries held
    trig_en_i = 1'b0; post_count_i = '0; out_ready_i = 1'b0;
    arm_i = 1'b1; tick(); arm_i = 1'b0;
    set_lanes(2'b11, 32'h10, 32'h14); tick();
    set_lanes(2'b11, 32'h18, 32'h1C); tick();
    set_lanes(2'b01, 32'h20, 32'h0);  tick();
    set_lanes(2'b00, 32'h0, 32'h0);
    check("t1_level_pre", level_o, 5);
    check("t1_state_pre", state_o, 2);
    rst_ni = 1'b0; tick(); rst_ni = 1'b1;
    check("t1_level", level_o, 0);
    check("t1_state", state_o, 0);
    check("t1_valid", out_valid_o, 0);
    check("t1_drop",  drop_cnt_o, 0);

    // Immediate capture, dual issue for 3 cycles, sink always ready (ts 1,1,2,2,3,3)
    out_ready_i = 1'b1;
    arm_i = 1'b1; tick(); arm_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) set_lanes(2'b11, 32'h100 + 8*i, 32'h104 + 8*i);
      else       set_lanes(2'b00, 32'h0, 32'h0);
      tick();
      check("t2_valid", out_valid_o, 1);
      check("t2_pc",    out_pc_o, 32'h100 + 4*i);
      check("t2_op",    out_opcode_o, (32'h100 + 4*i) ^ OPX);
      check("t2_ts",    out_ts_o, 1 + i/2);
      check("t2_lost",  out_lost_o, 0);
      if (i == 0) check("t2_state", state_o, 2);
    end
    tick();
    check("t2_empty", out_valid_o, 0);

    // Trigger on lane 1 only; then re-arm mid-capture and trigger on lane 0
    do_reset();
    trig_en_i = 1'b1; trig_pc_i = 32'h2008; out_ready_i = 1'b0;
    arm_i = 1'b1; tick(); arm_i = 1'b0;
    check("t3_armed", state_o, 1);
    set_lanes(2'b11, 32'h2000, 32'h2004); tick();
    check("t3_nomatch_state", state_o, 1);
    check("t3_nomatch_level", level_o, 0);
    set_lanes(2'b11, 32'h2004, 32'h2008); tick();
    check("t3_state", state_o, 2);
    check("t3_level", level_o, 1);
    check("t3_pc",    out_pc_o, 32'h2008);
    set_lanes(2'b00, 32'h0, 32'h0);
    arm_i = 1'b1; tick(); arm_i = 1'b0;
    check("t3_rearm_state", state_o, 1);
    check("t3_rearm_level", level_o, 1);
    set_lanes(2'b11, 32'h2008, 32'h200C); tick();
    check("t3_lane0_level", level_o, 3);
    check("t3_lane0_state", state_o, 2);
    set_lanes(2'b00, 32'h0, 32'h0);

    // Post-count of 3 across two dual-issue cycles
    do_reset();
    trig_en_i = 1'b0; post_count_i = 16'd3; out_ready_i = 1'b0;
    arm_i = 1'b1; tick(); arm_i = 1'b0;
    set_lanes(2'b11, 32'h300, 32'h304); tick();
    check("t4_state1", state_o, 2);
    check("t4_level1", level_o, 2);
    set_lanes(2'b11, 32'h308, 32'h30C); tick();
    check("t4_state2", state_o, 3);
    check("t4_level2", level_o, 3);
    check("t4_drop",   drop_cnt_o, 0);
    set_lanes(2'b11, 32'h310, 32'h314); tick();
    check("t4_done_level", level_o, 3);
    set_lanes(2'b00, 32'h0, 32'h0);
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t4_pc", out_pc_o, 32'h300 + 4*i);
      tick();
    end
    check("t4_empty", out_valid_o, 0);
    post_count_i = '0;

    // Overflow: 18 records into 16 slots, then one record after a single pop
    do_reset();
    out_ready_i = 1'b0;
    arm_i = 1'b1; tick(); arm_i = 1'b0;
    for (int k = 0; k < 9; k++) begin
      set_lanes(2'b11, 32'h500 + 8*k, 32'h504 + 8*k);
      tick();
    end
    set_lanes(2'b00, 32'h0, 32'h0);
    check("t5_level", level_o, 16);
    check("t5_drop",  drop_cnt_o, 2);
    check("t5_head_lost", out_lost_o, 0);
    out_ready_i = 1'b1; tick();
    check("t5_level_pop", level_o, 15);
    out_ready_i = 1'b0;
    set_lanes(2'b01, 32'h600, 32'h0); tick();
    set_lanes(2'b00, 32'h0, 32'h0);
    check("t5_level_new", level_o, 16);
    out_ready_i = 1'b1;
    for (int j = 1; j < 16; j++) begin
      check("t5_pc",   out_pc_o, 32'h500 + 4*j);
      check("t5_lost", out_lost_o, 0);
      tick();
    end
    check("t5_new_pc",   out_pc_o, 32'h600);
    check("t5_new_lost", out_lost_o, 1);
    tick();
    check("t5_empty", out_valid_o, 0);
    check("t5_drop_kept", drop_cnt_o, 2);

    // Stop and arm in the same cycle: stop wins, lanes ignored; arm from DONE re-arms
    do_reset();
    out_ready_i = 1'b0;
    arm_i = 1'b1; tick(); arm_i = 1'b0;
    check("t6_armed", state_o, 1);
    arm_i = 1'b1; stop_i = 1'b1;
    set_lanes(2'b11, 32'h700, 32'h704); tick();
    arm_i = 1'b0; stop_i = 1'b0;
    set_lanes(2'b00, 32'h0, 32'h0);
    check("t6_state", state_o, 3);
    check("t6_level", level_o, 0);
    arm_i = 1'b1; tick(); arm_i = 1'b0;
    check("t6_rearm", state_o, 1);

    // Timestamp wrap across consecutive records (captures in ts 0xFFFF and 0x0000 cycles)
    do_reset();
    out_ready_i = 1'b0;
    arm_i = 1'b1; tick(); arm_i = 1'b0;
    repeat (16'hFFFE) tick();
    set_lanes(2'b01, 32'hA0, 32'h0); tick();
    set_lanes(2'b01, 32'hA4, 32'h0); tick();
    set_lanes(2'b00, 32'h0, 32'h0);
    check("tw_level", level_o, 2);
    check("tw_pc0", out_pc_o, 32'hA0);
    check("tw_ts0", out_ts_o, 32'hFFFF);
    out_ready_i = 1'b1; tick();
    check("tw_pc1", out_pc_o, 32'hA4);
    check("tw_ts1", out_ts_o, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
